// File: rtl/pp_accum_seq_if.sv
// Operand/product handshake bundle for the sequential partial-product accumulator.
`timescale 1ns/1ps
interface pp_accum_seq_if #(
    parameter int unsigned ROWS  = 32,
    parameter int unsigned ROW_W = 64
);
    logic                    in_valid;
    logic                    in_ready;
    logic [ROWS*ROW_W-1:0]   pp;
    logic                    out_valid;
    logic                    out_ready;
    logic [ROW_W-1:0]        product;
    logic                    busy;

    // Upstream producer / downstream consumer side (testbench or parent).
    modport master (
        output in_valid, pp, out_ready,
        input  in_ready, out_valid, product, busy
    );

    // Accumulator side.
    modport slave (
        input  in_valid, pp, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/pp_accum_seq.sv
// Sequential partial-product accumulator: captures a ROWS x ROW_W bus, adds RPC
// rows per cycle into a ROW_W-bit accumulator and hands the sum out on valid/ready.
`timescale 1ns/1ps
module pp_accum_seq #(
    parameter int unsigned ROWS  = 32,
    parameter int unsigned ROW_W = 64,
    parameter int unsigned RPC   = 4     // 1, 2, 4 or 8; must divide ROWS
) (
    input  logic           clk,
    input  logic           rst_n,
    pp_accum_seq_if.slave  bus
);
    localparam int unsigned IDX_W    = $clog2(ROWS);
    localparam int unsigned PP_W     = ROWS * ROW_W;
    localparam int unsigned LAST_IDX = ROWS - RPC;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PP_W-1:0]    r_pp;
    logic [PP_W-1:0]    w_pp_nxt;
    logic [ROW_W-1:0]   r_acc;
    logic [ROW_W-1:0]   w_acc_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               r_in_ready;
    logic               w_in_ready_nxt;
    logic               r_out_valid;
    logic               w_out_valid_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic [ROW_W-1:0]   w_grp_sum;

    // Sum of the RPC captured rows starting at the current row index.
    always_comb begin
        w_grp_sum = '0;
        for (int unsigned j = 0; j < RPC; j++) begin
            w_grp_sum = w_grp_sum + r_pp[(32'(r_idx) + j) * ROW_W +: ROW_W];
        end
    end

    // Next-state, datapath and registered-output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_pp_nxt    = r_pp;
        w_acc_nxt   = r_acc;
        w_idx_nxt   = r_idx;

        case (r_state)
            S_IDLE: begin
                // r_in_ready also blocks the first edge after reset release.
                if (bus.in_valid && r_in_ready) begin
                    w_pp_nxt    = bus.pp;
                    w_acc_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                w_acc_nxt = r_acc + w_grp_sum;
                w_idx_nxt = r_idx + IDX_W'(RPC);
                if (r_idx == IDX_W'(LAST_IDX)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_in_ready_nxt  = (w_state_nxt == S_IDLE);
        w_out_valid_nxt = (w_state_nxt == S_DONE);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
    end

    // State, datapath and output registers; everything clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pp        <= '0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pp        <= w_pp_nxt;
            r_acc       <= w_acc_nxt;
            r_idx       <= w_idx_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.product   = r_acc;
endmodule
